hmmm_pgrm_tx: RTL

//  Transmit end of the hmmm serial programming port. Accepts (address, instruction) words over a

---
 rtl/hmmm_pkg.sv | 22 ++
 rtl/hmmm_pgrm_fifo.sv | 86 ++++++++
 rtl/hmmm_pgrm_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hmmm_pkg.sv
// Shared widths, FSM state encoding and sizing helper for the hmmm programming port.
package hmmm_pkg;

  localparam int unsigned HMMM_ADDR_W     = 8;
  localparam int unsigned HMMM_DATA_W     = 16;
  localparam int unsigned HMMM_FIFO_DEPTH = 4;
  localparam int unsigned HMMM_GAP_CYCLES = 2;
  localparam int unsigned HMMM_WCNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } pgrm_state_t;

  // Counter width able to index n states; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hmmm_pgrm_fifo.sv
// Synchronous word FIFO with flush, registered full/empty flags and registered read data.
module hmmm_pgrm_fifo
  import hmmm_pkg::*;
#(
  parameter int unsigned WIDTH = HMMM_ADDR_W + HMMM_DATA_W,
  parameter int unsigned DEPTH = HMMM_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = cnt_w(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  // Flush wins over both ports in the cycle it is sampled.
  assign w_push = i_wr_en & ~r_full  & ~i_flush;
  assign w_pop  = i_rd_en & ~r_empty & ~i_flush;

  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_rd_data <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
          r_rd_data <= r_mem[r_rd_ptr];
        end
      end
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/hmmm_pgrm_tx.sv
// Transmit end of the hmmm serial programming port: buffers (address, instruction) words
// and shifts each out as START + DATA_W shift cycles + GAP idle cycles.
module hmmm_pgrm_tx
  import hmmm_pkg::*;
#(
  parameter int unsigned ADDR_W     = HMMM_ADDR_W,
  parameter int unsigned DATA_W     = HMMM_DATA_W,
  parameter int unsigned FIFO_DEPTH = HMMM_FIFO_DEPTH,
  parameter int unsigned GAP_CYCLES = HMMM_GAP_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ADDR_W-1:0]      s_addr,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   flush,
  output logic                   pgrm_addr,
  output logic                   pgrm_data,
  output logic                   busy,
  output logic                   cpu_hold,
  output logic [HMMM_WCNT_W-1:0] words_sent
);

  localparam int unsigned FIFO_W = ADDR_W + DATA_W;
  localparam int unsigned BIT_W  = cnt_w(DATA_W);
  localparam int unsigned GAP_W  = cnt_w(GAP_CYCLES);
  localparam int unsigned WCNT_W = HMMM_WCNT_W;

  pgrm_state_t       r_state;
  pgrm_state_t       w_state_nxt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [ADDR_W-1:0] r_addr_sr;
  logic [DATA_W-1:0] r_data_sr;
  logic              r_pgrm_addr;
  logic              r_pgrm_data;
  logic              r_busy;
  logic              r_cpu_hold;
  logic [WCNT_W-1:0] r_words_sent;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [FIFO_W-1:0] w_fifo_rd_data;
  logic              w_push;
  logic              w_pop;
  logic              w_bit_last;
  logic              w_gap_last;
  logic              w_frame_done;

  // A pop coinciding with flush would launch a word that is being discarded, so flush blocks it.
  assign w_push       = s_valid & ~w_fifo_full;
  assign w_pop        = (r_state == IDLE) & ~w_fifo_empty & ~flush;
  assign w_bit_last   = (r_bit_cnt == BIT_W'(DATA_W - 1));
  assign w_gap_last   = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign w_frame_done = (r_state == GAP) & w_gap_last;

  hmmm_pgrm_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (flush),
    .i_wr_en   (w_push),
    .i_wr_data ({s_addr, s_data}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_rd_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pop)      w_state_nxt = START;
      START:                   w_state_nxt = SHIFT;
      SHIFT:   if (w_bit_last) w_state_nxt = GAP;
      GAP:     if (w_gap_last) w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  // Bit and gap counters only run inside their own state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (r_state == SHIFT && !w_bit_last) begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end else begin
        r_bit_cnt <= '0;
      end
      if (r_state == GAP && !w_gap_last) begin
        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  // The popped word lands in the FIFO read register during START and is loaded here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_sr <= '0;
      r_data_sr <= '0;
    end else if (r_state == START) begin
      r_addr_sr <= w_fifo_rd_data[FIFO_W-1:DATA_W];
      r_data_sr <= w_fifo_rd_data[DATA_W-1:0];
    end else if (r_state == SHIFT) begin
      r_addr_sr <= {r_addr_sr[ADDR_W-2:0], 1'b0};
      r_data_sr <= {r_data_sr[DATA_W-2:0], 1'b0};
    end
  end

  // Line and status registers follow the state one cycle behind so they stay frame-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pgrm_addr  <= 1'b0;
      r_pgrm_data  <= 1'b0;
      r_busy       <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_words_sent <= '0;
    end else begin
      case (r_state)
        START: begin
          r_pgrm_addr <= 1'b1;
          r_pgrm_data <= 1'b1;
        end
        SHIFT: begin
          r_pgrm_addr <= r_addr_sr[ADDR_W-1];
          r_pgrm_data <= r_data_sr[DATA_W-1];
        end
        default: begin
          r_pgrm_addr <= 1'b0;
          r_pgrm_data <= 1'b0;
        end
      endcase
      r_busy     <= (r_state != IDLE);
      r_cpu_hold <= (r_state != IDLE) | ~w_fifo_empty;
      if (w_frame_done) begin
        r_words_sent <= r_words_sent + WCNT_W'(1);
      end
    end
  end

  assign s_ready    = ~w_fifo_full;
  assign pgrm_addr  = r_pgrm_addr;
  assign pgrm_data  = r_pgrm_data;
  assign busy       = r_busy;
  assign cpu_hold   = r_cpu_hold;
  assign words_sent = r_words_sent;

endmodule
